// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
//   Bit-serial N-bit adder/subtractor. A single full-adder cell plus a carry
//   flip-flop process one operand bit per clock, LSB first.
//
//   Subtraction is done as a + ~b + ~borrow_in. The carry register therefore
//   starts at ~c_in, and the final carry is inverted again to give a borrow.
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous active-high reset (overrides everything)
//   start  request a new operation; accepted whenever not busy
//   sub    0 = add, 1 = subtract (captured with start)
//   a, b   N-bit operands (captured with start)
//   c_in   carry-in (add) / borrow-in (sub) (captured with start)
//   sum    result; valid from the done pulse until the next accepted start
//   c_out  carry-out (add) / borrow-out (sub)
//   ovf    two's-complement signed overflow
//   busy   high while bits are being processed
//   done   one-cycle pulse, result valid
// -----------------------------------------------------------------------------
module serial_addsub #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         ovf,
    output logic         busy,
    output logic         done
);

    // Counter is at least one bit wide so N=1 still elaborates cleanly.
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_reg;
    logic [N-1:0]   a_sh_reg;
    logic [N-1:0]   b_sh_reg;
    logic [N-1:0]   sum_reg;
    logic           sub_reg;
    logic           carry_reg;
    logic [CW-1:0]  cnt_reg;
    logic           c_out_reg;
    logic           ovf_reg;
    logic           busy_reg;
    logic           done_reg;

    logic [N-1:0]   a_sh_next;
    logic [N-1:0]   b_sh_next;
    logic [N-1:0]   sum_next;
    logic           fa_a;
    logic           fa_b;
    logic           fa_s;
    logic           fa_c;
    logic           load;

    // The single full-adder cell; b is inverted on the fly when subtracting.
    assign fa_a = a_sh_reg[0];
    assign fa_b = b_sh_reg[0] ^ sub_reg;
    assign fa_s = fa_a ^ fa_b ^ carry_reg;
    assign fa_c = (fa_a & fa_b) | (fa_a & carry_reg) | (fa_b & carry_reg);

    // Right shifts: operands drain LSB first, new sum bits enter at the MSB.
    generate
        for (genvar gi = 0; gi < N - 1; gi++) begin : g_shift
            assign a_sh_next[gi] = a_sh_reg[gi+1];
            assign b_sh_next[gi] = b_sh_reg[gi+1];
            assign sum_next[gi]  = sum_reg[gi+1];
        end
    endgenerate
    assign a_sh_next[N-1] = 1'b0;
    assign b_sh_next[N-1] = 1'b0;
    assign sum_next[N-1]  = fa_s;

    // A start is honoured in IDLE and also in DONE (back-to-back operation).
    assign load = start && (state_reg != RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            sum_reg   <= '0;
            sub_reg   <= 1'b0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            c_out_reg <= 1'b0;
            ovf_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (load) begin
                state_reg <= RUN;
                a_sh_reg  <= a;
                b_sh_reg  <= b;
                sub_reg   <= sub;
                carry_reg <= sub ? ~c_in : c_in;
                cnt_reg   <= '0;
                busy_reg  <= 1'b1;
            end else if (state_reg == RUN) begin
                a_sh_reg  <= a_sh_next;
                b_sh_reg  <= b_sh_next;
                sum_reg   <= sum_next;
                carry_reg <= fa_c;
                cnt_reg   <= cnt_reg + CW'(1);
                if (cnt_reg == LAST) begin
                    state_reg <= DONE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    // carry_reg is the carry into the MSB, fa_c the carry out.
                    c_out_reg <= fa_c ^ sub_reg;
                    ovf_reg   <= carry_reg ^ fa_c;
                end
            end else begin
                state_reg <= IDLE;
            end
        end
    end

    assign sum   = sum_reg;
    assign c_out = c_out_reg;
    assign ovf   = ovf_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;

endmodule

// File: tb/tb_serial_addsub.sv
// -----------------------------------------------------------------------------
// tb_serial_addsub
//   Drives an N=8 and an N=1 instance of serial_addsub. Expected results come
//   from an arithmetic reference model and go into per-instance queues; a
//   forked monitor pops and compares whenever done is seen.
// -----------------------------------------------------------------------------
module tb_serial_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start8, sub8, cin8;
    logic [7:0] a8, b8;
    logic [7:0] sum8;
    logic       cout8, ovf8, busy8, done8;

    logic       start1, sub1, cin1;
    logic [0:0] a1, b1;
    logic [0:0] sum1;
    logic       cout1, ovf1, busy1, done1;

    int compared   = 0;
    int mismatched = 0;

    logic [33:0] q8[$];
    logic [33:0] q1[$];
    logic [7:0]  last_sum8;

    serial_addsub #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .c_in(cin8), .sum(sum8), .c_out(cout8), .ovf(ovf8), .busy(busy8),
        .done(done8)
    );

    serial_addsub #(.N(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1),
        .c_in(cin1), .sum(sum1), .c_out(cout1), .ovf(ovf1), .busy(busy1),
        .done(done1)
    );

    task automatic check(input string name, input longint got, input longint exp);
        compared++;
        if (got != exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic. Returns {ovf, c_out, 32-bit sum}.
    function automatic logic [33:0] model(input int n, input bit s,
                                          input longint a, input longint b,
                                          input bit c);
        longint lim, half, cl, full, sa, sb, r;
        logic [31:0] sm;
        bit co, ov;
        lim  = longint'(1) << n;
        half = lim >> 1;
        cl   = c ? 64'sd1 : 64'sd0;
        if (!s) begin
            full = a + b + cl;
            co   = (full >= lim);
        end else begin
            full = a - b - cl;
            co   = (a < b + cl);
        end
        sm = 32'(full & (lim - 1));
        sa = (a >= half) ? a - lim : a;
        sb = (b >= half) ? b - lim : b;
        r  = s ? (sa - sb - cl) : (sa + sb + cl);
        ov = (r < -half) || (r > half - 1);
        return {ov, co, sm};
    endfunction

    // Issue one operation on the N=8 instance. Called right after a negedge;
    // returns at the negedge where done is seen. With glitch set, a start with
    // different operands is pulsed mid-RUN and must be ignored.
    task automatic op8(input bit s, input logic [7:0] a, input logic [7:0] b,
                       input bit c, input bit glitch);
        int k, busy_n;
        logic [33:0] e;
        e = model(8, s, longint'(a), longint'(b), c);
        q8.push_back(e);
        last_sum8 = e[7:0];
        sub8 = s; a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        k = 0; busy_n = 0;
        while (1) begin
            @(negedge clk);
            k++;
            start8 = 1'b0;
            if (glitch && k == 3) begin
                start8 = 1'b1; a8 = 8'hFF; b8 = 8'h55; sub8 = ~s; cin8 = ~c;
            end
            if (busy8) busy_n++;
            if (done8) break;
            if (k >= 40) break;
        end
        check("latency8", longint'(k), 64'd9);
        check("busy_cycles8", longint'(busy_n), 64'd8);
    endtask

    task automatic op1(input bit s, input bit a, input bit b, input bit c);
        int k, busy_n;
        q1.push_back(model(1, s, a ? 64'd1 : 64'd0, b ? 64'd1 : 64'd0, c));
        sub1 = s; a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
        k = 0; busy_n = 0;
        while (1) begin
            @(negedge clk);
            k++;
            start1 = 1'b0;
            if (busy1) busy_n++;
            if (done1) break;
            if (k >= 20) break;
        end
        check("latency1", longint'(k), 64'd2);
        check("busy_cycles1", longint'(busy_n), 64'd1);
    endtask

    initial begin
        logic [33:0] e;
        int seen;
        int gap;
        logic [7:0] ra, rb;

        rst = 1'b1;
        start8 = 0; sub8 = 0; cin8 = 0; a8 = '0; b8 = '0;
        start1 = 0; sub1 = 0; cin1 = 0; a1 = '0; b1 = '0;
        last_sum8 = '0;

        fork
            forever begin
                @(negedge clk);
                if (done8) begin
                    if (q8.size() == 0) begin
                        check("unexpected_done8", 64'd1, 64'd0);
                    end else begin
                        e = q8.pop_front();
                        check("result8", longint'({ovf8, cout8, 24'h0, sum8}), longint'(e));
                    end
                end
                if (done1) begin
                    if (q1.size() == 0) begin
                        check("unexpected_done1", 64'd1, 64'd0);
                    end else begin
                        e = q1.pop_front();
                        check("result1", longint'({ovf1, cout1, 31'h0, sum1}), longint'(e));
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check("reset_state8", longint'({busy8, done8, sum8, cout8, ovf8}), 64'd0);
        check("reset_state1", longint'({busy1, done1, sum1, cout1, ovf1}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed adds
        op8(0, 8'h00, 8'h00, 0, 0); @(negedge clk);
        op8(0, 8'hFF, 8'h01, 0, 0); @(negedge clk);
        op8(0, 8'h7F, 8'h01, 0, 0);
        repeat (3) @(negedge clk);
        check("hold_sum8", longint'(sum8), 64'h80);
        check("hold_ovf8", longint'(ovf8), 64'd1);
        op8(0, 8'h01, 8'h01, 1, 0); @(negedge clk);
        // Directed subtracts
        op8(1, 8'h00, 8'h01, 0, 0); @(negedge clk);
        op8(1, 8'h80, 8'h01, 0, 0); @(negedge clk);
        op8(1, 8'h05, 8'h02, 1, 0); @(negedge clk);

        // Start ignored mid-RUN, then back-to-back start straight from DONE
        op8(0, 8'h10, 8'h20, 0, 1);
        op8(0, 8'h22, 8'h33, 0, 0);
        @(negedge clk);

        // Reset during the 4th RUN cycle abandons the operation
        sub8 = 0; a8 = 8'h11; b8 = 8'h22; cin8 = 0; start8 = 1'b1;
        repeat (4) begin
            @(negedge clk);
            start8 = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("midrun_reset8", longint'({busy8, done8, sum8, cout8, ovf8}), 64'd0);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) seen++;
        end
        check("no_done_after_reset", longint'(seen), 64'd0);
        op8(0, 8'h03, 8'h04, 0, 0); @(negedge clk);

        // Random operations with random gaps (0 gap = back-to-back)
        for (int i = 0; i < 150; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            op8(1'($urandom), ra, rb, 1'($urandom), 1'($urandom_range(0, 7) == 0));
            gap = int'($urandom_range(0, 2));
            if (gap > 0) begin
                repeat (gap) @(negedge clk);
                check("hold_sum8_rand", longint'(sum8), longint'(last_sum8));
            end
        end
        @(negedge clk);

        // N=1: exhaustive over {sub, a, b, c_in}
        for (int i = 0; i < 16; i++) begin
            op1(i[3], i[2], i[1], i[0]);
            @(negedge clk);
        end

        repeat (4) @(negedge clk);
        check("queue8_drained", longint'(q8.size()), 64'd0);
        check("queue1_drained", longint'(q1.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
